gtech_fjk_scan_bank: RTL and testbench
======================================

GTECH_FJK_SCAN_BANK -- requirements
Module: gtech_fjk_scan_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of JK flip-flop bits; legal range 1..64.
REQ-002 Parameter RST_VAL, default all-zero, WIDTH bits: value loaded into Q on reset.
REQ-003 Port CP, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port EN, input, 1 bit: functional-mode update enable.
REQ-006 Port J, input, WIDTH bits: per-bit J inputs.
REQ-007 Port K, input, WIDTH bits: per-bit K inputs.
REQ-008 Port TE, input, 1 bit: scan enable; selects serial shift mode.
REQ-009 Port TI, input, 1 bit: scan serial input.
REQ-010 Port Q, output, WIDTH bits: registered state.
REQ-011 Port QN, output, WIDTH bits: bitwise complement of Q, combinational.
REQ-012 Port SO, output, 1 bit: scan serial output, equal to Q[WIDTH-1], combinational from state.
REQ-013 Port TGL, output, 1 bit: registered flag, high for one cycle after any edge where at least one bit toggled through JK=11.

Function
REQ-014 Per-edge priority SHALL be RST, then TE, then EN, then hold.
REQ-015 RST=1: Q <= RST_VAL and TGL <= 0, regardless of TE, EN, J, K.
REQ-016 RST=0, TE=1: Q <= {Q[WIDTH-2:0], TI}; TI enters bit 0; old Q[WIDTH-1] shifts out; TGL <= 0.
REQ-017 WIDTH=1 with TE=1: Q <= TI.
REQ-018 RST=0, TE=0, EN=1: each bit i updates independently: JK=00 hold, 01 -> 0, 10 -> 1, 11 -> ~Q[i].
REQ-019 RST=0, TE=0, EN=1: TGL <= OR over i of (J[i] & K[i]); otherwise TGL <= 0.
REQ-020 RST=0, TE=0, EN=0: Q holds; J, K ignored; TGL <= 0.
REQ-021 Latency: Q, SO and TGL reflect new state one CP edge after the controlling inputs are sampled; QN tracks Q with zero cycles.
REQ-022 A full scan load of WIDTH bits SHALL take exactly WIDTH consecutive TE=1 edges; the first bit shifted in appears on SO after the WIDTH-th edge.
REQ-023 A TE deassertion mid-shift SHALL leave the partial shifted state in Q; functional updates resume from that state on the next EN=1 edge.
REQ-024 RST asserted mid-shift or mid-toggle sequence SHALL override on that edge with no residual state.
REQ-025 X on J or K with TE=1 or EN=0 SHALL NOT affect Q.
REQ-026 No latches, no asynchronous paths; Q and TGL are the only storage (WIDTH+1 flops).

Reset
REQ-027 After any edge with RST=1: Q=RST_VAL, QN=~RST_VAL, SO=RST_VAL[WIDTH-1], TGL=0.
REQ-028 Q is undefined from power-up until the first RST=1 edge; no initial-value reliance.

Verification (WIDTH=8, RST_VAL=8'h00 unless stated)
REQ-029 RST=1 one edge, then EN=1, J=8'hF0, K=8'h0F -> Q=8'hF0, QN=8'h0F, TGL=0.
REQ-030 From Q=8'hF0, EN=1, J=K=8'hFF, two edges -> Q=8'h0F then 8'hF0, TGL=1 each cycle; then J=K=0 -> Q holds 8'hF0, TGL=0.
REQ-031 From Q=8'h00, TE=1, TI sequence 1,0,1,1,0,0,1,0 over 8 edges -> Q=8'hB2, SO=1 after 8th edge; 8 further edges with TI=0 -> SO replays 1,0,1,1,0,0,1,0, Q=8'h00.
REQ-032 TE=1 and EN=1, J=K=8'hFF simultaneously -> shift only, no toggle, TGL=0.
REQ-033 RST=1 coincident with TE=1 mid-shift, RST_VAL=8'hA5 instance -> Q=8'hA5, SO=1, TGL=0 on that edge.
REQ-034 WIDTH=1 instance: TE=1, TI=1 -> Q=1, SO=1; TE=0, EN=1, J=K=1 -> Q=0, TGL=1.

Source files
------------

// File: rtl/gtech_fjk_scan_bank.sv
// gtech_fjk_scan_bank
//   A bank of WIDTH JK flip-flops sharing one clock, with a serial scan chain
//   threaded through the bank and a registered "some bit toggled" flag.
//
//   Edge priority: RST, then scan shift (TE), then functional JK update (EN),
//   otherwise hold. All storage is Q (WIDTH flops) plus TGL (one flop).
//
// Ports
//   CP   in   1      clock, rising edge
//   RST  in   1      synchronous active-high reset; loads RST_VAL, clears TGL
//   EN   in   1      functional-mode update enable
//   J    in   WIDTH  per-bit J inputs
//   K    in   WIDTH  per-bit K inputs
//   TE   in   1      scan enable; shifts Q left by one with TI entering bit 0
//   TI   in   1      scan serial input
//   Q    out  WIDTH  registered state
//   QN   out  WIDTH  ~Q, combinational
//   SO   out  1      scan serial output, Q[WIDTH-1]
//   TGL  out  1      registered; high for one cycle after an edge where any
//                    bit saw JK=11 in functional mode
module gtech_fjk_scan_bank #(
  parameter int unsigned     WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CP,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             TE,
  input  logic             TI,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             SO,
  output logic             TGL
);

  logic [WIDTH-1:0] q_q;
  logic             tgl_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] jk_d;
  logic             any_toggle;

  // A single-bit bank has no upper slice to shift, so TI simply replaces Q.
  if (WIDTH == 1) begin : g_shift_w1
    assign shift_d = TI;
  end else begin : g_shift_wn
    assign shift_d = {q_q[WIDTH-2:0], TI};
  end

  // Classic JK next-state: 00 hold, 01 clear, 10 set, 11 toggle.
  assign jk_d       = (J & ~q_q) | (~K & q_q);
  assign any_toggle = |(J & K);

  // J and K are only consumed on the EN branch, so unknowns on them cannot
  // reach the state while shifting or holding.
  always_ff @(posedge CP) begin
    if (RST) begin
      q_q   <= RST_VAL;
      tgl_q <= 1'b0;
    end else if (TE) begin
      q_q   <= shift_d;
      tgl_q <= 1'b0;
    end else if (EN) begin
      q_q   <= jk_d;
      tgl_q <= any_toggle;
    end else begin
      tgl_q <= 1'b0;
    end
  end

  assign Q   = q_q;
  assign QN  = ~q_q;
  assign SO  = q_q[WIDTH-1];
  assign TGL = tgl_q;

endmodule

// File: tb/tb_gtech_fjk_scan_bank.sv
// Scoreboard bench for gtech_fjk_scan_bank. Three instances share one clock:
//   a: WIDTH=8, RST_VAL=8'h00   b: WIDTH=8, RST_VAL=8'hA5   c: WIDTH=1
// The driver applies one directed vector per cycle to one instance and pushes
// the hand-computed post-edge state; the monitor pops after each edge and
// compares Q, QN, SO and TGL of the addressed instance.
module tb_gtech_fjk_scan_bank;

  typedef struct {
    int         sel;
    string      name;
    logic [7:0] q;
    logic       tgl;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_en, a_te, a_ti;
  logic [7:0] a_j, a_k, a_q, a_qn;
  logic       a_so, a_tgl;
  logic       b_rst, b_en, b_te, b_ti;
  logic [7:0] b_j, b_k, b_q, b_qn;
  logic       b_so, b_tgl;
  logic       c_rst, c_en, c_te, c_ti;
  logic [0:0] c_j, c_k, c_q, c_qn;
  logic       c_so, c_tgl;

  gtech_fjk_scan_bank #(.WIDTH(8), .RST_VAL(8'h00)) u_a (
    .CP(clk), .RST(a_rst), .EN(a_en), .J(a_j), .K(a_k), .TE(a_te), .TI(a_ti),
    .Q(a_q), .QN(a_qn), .SO(a_so), .TGL(a_tgl)
  );

  gtech_fjk_scan_bank #(.WIDTH(8), .RST_VAL(8'hA5)) u_b (
    .CP(clk), .RST(b_rst), .EN(b_en), .J(b_j), .K(b_k), .TE(b_te), .TI(b_ti),
    .Q(b_q), .QN(b_qn), .SO(b_so), .TGL(b_tgl)
  );

  gtech_fjk_scan_bank #(.WIDTH(1), .RST_VAL(1'b0)) u_c (
    .CP(clk), .RST(c_rst), .EN(c_en), .J(c_j), .K(c_k), .TE(c_te), .TI(c_ti),
    .Q(c_q), .QN(c_qn), .SO(c_so), .TGL(c_tgl)
  );

  task automatic check(input string name, input string field,
                       input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s.%s: got %h, expected %h", name, field, got, want);
    end
  endtask

  // Monitor: one sample per edge, #1 after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.sel)
          0: begin
            check(e.name, "Q",   a_q,          e.q);
            check(e.name, "QN",  a_qn,         ~e.q);
            check(e.name, "SO",  {7'b0, a_so}, {7'b0, e.q[7]});
            check(e.name, "TGL", {7'b0, a_tgl}, {7'b0, e.tgl});
          end
          1: begin
            check(e.name, "Q",   b_q,          e.q);
            check(e.name, "QN",  b_qn,         ~e.q);
            check(e.name, "SO",  {7'b0, b_so}, {7'b0, e.q[7]});
            check(e.name, "TGL", {7'b0, b_tgl}, {7'b0, e.tgl});
          end
          default: begin
            check(e.name, "Q",   {7'b0, c_q},   {7'b0, e.q[0]});
            check(e.name, "QN",  {7'b0, c_qn},  {7'b0, ~e.q[0]});
            check(e.name, "SO",  {7'b0, c_so},  {7'b0, e.q[0]});
            check(e.name, "TGL", {7'b0, c_tgl}, {7'b0, e.tgl});
          end
        endcase
      end
    end
  end

  // Driver: sets inputs of the selected instance, parks the others in hold,
  // and records the expected state after the coming edge.
  task automatic step(input int sel, input string name,
                      input logic rst, input logic te, input logic ti, input logic en,
                      input logic [7:0] j, input logic [7:0] k,
                      input logic [7:0] q, input logic tgl);
    exp_t e;
    @(posedge clk);
    #2;
    a_rst = 0; a_te = 0; a_en = 0;
    b_rst = 0; b_te = 0; b_en = 0;
    c_rst = 0; c_te = 0; c_en = 0;
    case (sel)
      0: begin a_rst = rst; a_te = te; a_ti = ti; a_en = en; a_j = j; a_k = k; end
      1: begin b_rst = rst; b_te = te; b_ti = ti; b_en = en; b_j = j; b_k = k; end
      default: begin
        c_rst = rst; c_te = te; c_ti = ti; c_en = en; c_j = j[0]; c_k = k[0];
      end
    endcase
    e.sel = sel; e.name = name; e.q = q; e.tgl = tgl;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [7:0] ti_seq;
    logic [7:0] shq_in [8];
    logic [7:0] shq_out[8];
    int         wait_cnt;
    ti_seq  = 8'b1011_0010;  // TI order 1,0,1,1,0,0,1,0 (MSB first)
    shq_in  = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
    shq_out = '{8'h64, 8'hC8, 8'h90, 8'h20, 8'h40, 8'h80, 8'h00, 8'h00};

    a_rst = 0; a_te = 0; a_ti = 0; a_en = 0; a_j = 0; a_k = 0;
    b_rst = 0; b_te = 0; b_ti = 0; b_en = 0; b_j = 0; b_k = 0;
    c_rst = 0; c_te = 0; c_ti = 0; c_en = 0; c_j = 0; c_k = 0;

    // Instance a: JK function
    step(0, "a_reset",     1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    step(0, "a_set_clr",   0, 0, 0, 1, 8'hF0, 8'h0F, 8'hF0, 0);
    step(0, "a_toggle1",   0, 0, 0, 1, 8'hFF, 8'hFF, 8'h0F, 1);
    step(0, "a_toggle2",   0, 0, 0, 1, 8'hFF, 8'hFF, 8'hF0, 1);
    step(0, "a_jk00_hold", 0, 0, 0, 1, 8'h00, 8'h00, 8'hF0, 0);
    step(0, "a_en0_hold",  0, 0, 0, 0, 8'hFF, 8'hFF, 8'hF0, 0);
    step(0, "a_en0_x",     0, 0, 0, 0, 'x,    'x,    8'hF0, 0);
    step(0, "a_reset2",    1, 0, 0, 1, 8'hFF, 8'hFF, 8'h00, 0);
    // Scan load then unload
    for (int i = 0; i < 8; i++)
      step(0, $sformatf("a_scan_in%0d", i), 0, 1, ti_seq[7-i], 0, 8'h00, 8'h00,
           shq_in[i], 0);
    for (int i = 0; i < 8; i++)
      step(0, $sformatf("a_scan_out%0d", i), 0, 1, 0, 0, 8'h00, 8'h00, shq_out[i], 0);
    // Shift wins over toggle; unknown J/K ignored while shifting
    step(0, "a_te_over_en", 0, 1, 1, 1, 8'hFF, 8'hFF, 8'h01, 0);
    step(0, "a_te_x",       0, 1, 1, 1, 'x,    'x,    8'h03, 0);
    // Partial shift left in place, functional update resumes from it
    step(0, "a_resume",     0, 0, 0, 1, 8'h01, 8'h02, 8'h01, 0);
    step(0, "a_resume_tgl", 0, 0, 0, 1, 8'h03, 8'h03, 8'h02, 1);
    step(0, "a_rst_midtgl", 1, 0, 0, 1, 8'hFF, 8'hFF, 8'h00, 0);

    // Instance b: nonzero reset value
    step(1, "b_reset",      1, 0, 0, 0, 8'h00, 8'h00, 8'hA5, 0);
    step(1, "b_shift0",     0, 1, 0, 0, 8'h00, 8'h00, 8'h4A, 0);
    step(1, "b_shift1",     0, 1, 1, 0, 8'h00, 8'h00, 8'h95, 0);
    step(1, "b_rst_midsh",  1, 1, 0, 1, 8'hFF, 8'hFF, 8'hA5, 0);
    step(1, "b_toggle",     0, 0, 0, 1, 8'h0F, 8'h0F, 8'hAA, 1);
    step(1, "b_rst_tgl",    1, 0, 0, 1, 8'hFF, 8'hFF, 8'hA5, 0);

    // Instance c: single bit
    step(2, "c_reset",      1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    step(2, "c_scan",       0, 1, 1, 0, 8'h00, 8'h00, 8'h01, 0);
    step(2, "c_toggle",     0, 0, 0, 1, 8'h01, 8'h01, 8'h00, 1);
    step(2, "c_set",        0, 0, 0, 1, 8'h01, 8'h00, 8'h01, 0);
    step(2, "c_clr",        0, 0, 0, 1, 8'h00, 8'h01, 8'h00, 0);
    step(2, "c_hold",       0, 0, 0, 0, 8'h01, 8'h01, 8'h00, 0);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
